// File: rtl/screen_timing_pkg.sv
// Display constants shared by the timing generator and the raycaster.
// Also holds the counter width and a small window-decode helper.
package screen_timing_pkg;

    localparam int DISP_H_RES = 640;
    localparam int DISP_V_RES = 480;
    localparam int CNT_W      = 10;

    // True when lo <= v < hi.
    function automatic logic in_window(
        input logic [CNT_W-1:0] v,
        input logic [CNT_W-1:0] lo,
        input logic [CNT_W-1:0] hi
    );
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/screen_timing_if.sv
// Beam position and sync/enable bundle carried from the timing generator
// to the video consumers.
interface screen_timing_if;
    import screen_timing_pkg::*;

    logic [CNT_W-1:0] sx_out;
    logic [CNT_W-1:0] sy_out;
    logic             hsync_out;
    logic             vsync_out;
    logic             de_out;

    modport master (output sx_out, sy_out, hsync_out, vsync_out, de_out);
    modport slave  (input  sx_out, sy_out, hsync_out, vsync_out, de_out);

endinterface

// File: rtl/screen_timing.sv
// Free-running raster timing generator (640x480@60 by default).
// Sync and data-enable are decoded from the next counter values and registered
// alongside the counters, so every output changes on the same edge.
module screen_timing
    import screen_timing_pkg::*;
#(
    parameter int H_RES  = DISP_H_RES,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_RES  = DISP_V_RES,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter bit H_POL  = 1'b0,
    parameter bit V_POL  = 1'b0
) (
    input  logic           clk_in,
    input  logic           rst_in,
    screen_timing_if.master vid
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    if ((H_TOTAL > (1 << CNT_W)) || (V_TOTAL > (1 << CNT_W))) begin : g_size_chk
        $error("screen_timing: raster totals do not fit in the position counters");
    end

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_RES);
    localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_RES);
    localparam logic [CNT_W-1:0] H_SYNC_LO  = CNT_W'(H_RES + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_HI  = CNT_W'(H_RES + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_LO  = CNT_W'(V_RES + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_HI  = CNT_W'(V_RES + V_FP + V_SYNC);

    logic [CNT_W-1:0] r_sx;
    logic [CNT_W-1:0] r_sy;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;

    logic [CNT_W-1:0] w_sx_nxt;
    logic [CNT_W-1:0] w_sy_nxt;
    logic             w_hsync_nxt;
    logic             w_vsync_nxt;
    logic             w_de_nxt;

    // Next beam position plus lookahead decode of sync and data enable.
    always_comb begin
        w_sx_nxt = r_sx + CNT_W'(1);
        w_sy_nxt = r_sy;
        if (r_sx == H_LAST) begin
            w_sx_nxt = '0;
            if (r_sy == V_LAST) begin
                w_sy_nxt = '0;
            end else begin
                w_sy_nxt = r_sy + CNT_W'(1);
            end
        end else begin
            w_sy_nxt = r_sy;
        end
        w_de_nxt    = (w_sx_nxt < H_ACT) && (w_sy_nxt < V_ACT);
        w_hsync_nxt = in_window(w_sx_nxt, H_SYNC_LO, H_SYNC_HI) ? H_POL : ~H_POL;
        w_vsync_nxt = in_window(w_sy_nxt, V_SYNC_LO, V_SYNC_HI) ? V_POL : ~V_POL;
    end

    // Counter and output registers; reset parks the beam at the top-left pixel.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sx    <= '0;
            r_sy    <= '0;
            r_de    <= 1'b1;
            r_hsync <= ~H_POL;
            r_vsync <= ~V_POL;
        end else begin
            r_sx    <= w_sx_nxt;
            r_sy    <= w_sy_nxt;
            r_de    <= w_de_nxt;
            r_hsync <= w_hsync_nxt;
            r_vsync <= w_vsync_nxt;
        end
    end

    assign vid.sx_out    = r_sx;
    assign vid.sy_out    = r_sy;
    assign vid.hsync_out = r_hsync;
    assign vid.vsync_out = r_vsync;
    assign vid.de_out    = r_de;

endmodule

// File: tb/tb_screen_timing.sv
// Checks a default 640x480 generator and a shrunken, hsync-active-high one
// against a raster model derived from the elapsed clock count since reset.
module tb_screen_timing;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   t   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    screen_timing_if u_if_def ();
    screen_timing_if u_if_sml ();

    screen_timing u_dut_def (
        .clk_in (clk),
        .rst_in (rst),
        .vid    (u_if_def.master)
    );

    screen_timing #(
        .H_RES(40), .H_FP(4), .H_SYNC(8), .H_BP(6),
        .V_RES(30), .V_FP(3), .V_SYNC(2), .V_BP(5),
        .H_POL(1'b1), .V_POL(1'b0)
    ) u_dut_sml (
        .clk_in (clk),
        .rst_in (rst),
        .vid    (u_if_sml.master)
    );

    localparam int SML_HT = 58;
    localparam int SML_VT = 40;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0d: got %0d expected %0d", tag, t, obs, exp);
        end
    endtask

    // Expected raster state after t clocks of free running from (0,0).
    task automatic check_inst(
        input string nm,
        input int hr, input int hfp, input int hs, input int hbp,
        input int vr, input int vfp, input int vs, input int vbp,
        input bit hp, input bit vp,
        input logic [9:0] sx, input logic [9:0] sy,
        input logic hsync, input logic vsync, input logic de
    );
        int ht, vt, ex, ey;
        ht = hr + hfp + hs + hbp;
        vt = vr + vfp + vs + vbp;
        ex = t % ht;
        ey = (t / ht) % vt;
        chk({nm, ".sx"}, 32'(sx), 32'(ex));
        chk({nm, ".sy"}, 32'(sy), 32'(ey));
        chk({nm, ".de"}, 32'(de), 32'((ex < hr) && (ey < vr)));
        chk({nm, ".hsync"}, 32'(hsync),
            32'(((ex >= hr + hfp) && (ex < hr + hfp + hs)) ? hp : !hp));
        chk({nm, ".vsync"}, 32'(vsync),
            32'(((ey >= vr + vfp) && (ey < vr + vfp + vs)) ? vp : !vp));
    endtask

    task automatic step(input logic r);
        rst = r;
        @(posedge clk);
        t = r ? 0 : t + 1;
        @(negedge clk);
        check_inst("def", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0,
                   u_if_def.sx_out, u_if_def.sy_out, u_if_def.hsync_out,
                   u_if_def.vsync_out, u_if_def.de_out);
        check_inst("sml", 40, 4, 8, 6, 30, 3, 2, 5, 1'b1, 1'b0,
                   u_if_sml.sx_out, u_if_sml.sy_out, u_if_sml.hsync_out,
                   u_if_sml.vsync_out, u_if_sml.de_out);
    endtask

    initial begin
        bit found;

        // Reset held for three clocks, then two full small frames and a bit.
        for (int i = 0; i < 3; i++) step(1'b1);
        for (int i = 0; i < 2 * SML_HT * SML_VT + 10; i++) step(1'b0);

        // Seek the small raster to (sy,sx) = (20,13) and reset there for one cycle.
        found = 1'b0;
        for (int i = 0; i < SML_HT * SML_VT + 1 && !found; i++) begin
            if ((t % (SML_HT * SML_VT)) == 20 * SML_HT + 13) begin
                found = 1'b1;
            end else begin
                step(1'b0);
            end
        end
        chk("seek", 32'(found), 32'd1);
        step(1'b1);
        for (int i = 0; i < SML_HT * SML_VT + 100; i++) step(1'b0);

        // Random sparse resets of random length.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                int len;
                len = int'($urandom_range(1, 3));
                for (int k = 0; k < len; k++) step(1'b1);
            end else begin
                step(1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
